voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Sits between song_reader and a bank of NUM_VOICES note_player voices.
- Accepts each new_note event, allocates a voice for the pitch, and times every voice's duration in beats.
- Returns the sequencing handshakes song_reader waits on:
  - note_done for normal notes (activate=0), raised when the note's duration expires.
  - activate_done for chord notes (activate=1), raised immediately so the next note sounds simultaneously.

Parameters:
NUM_VOICES, 3, number of note_player voices managed (2..8)
NOTE_WIDTH, 6, note code width; code 0 = rest
DURATION_WIDTH, 6, duration width in beats

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
play  in  1  1 = beats counted; 0 = all timers frozen, voices keep sounding state
flush  in  1  synchronous clear of all voices and gate timer (song change/stop)
new_note  in  1  one-cycle pulse from song_reader, note/duration/activate valid this cycle
note  in  NOTE_WIDTH  pitch code
duration  in  DURATION_WIDTH  length in beats
activate  in  1  1 = chord note (do not hold sequencer), 0 = normal note
beat  in  1  one-cycle beat strobe
note_done  out  1  one-cycle pulse: normal note's duration expired
activate_done  out  1  one-cycle pulse: chord note accepted
voice_load  out  NUM_VOICES  one-cycle pulse per voice: restart with new pitch
voice_active  out  NUM_VOICES  voice is sounding
voice_note  out  NUM_VOICES*NOTE_WIDTH  flattened pitch per voice, voice k at [k*NOTE_WIDTH +: NOTE_WIDTH]

Behaviour:
- Reset (reset=0, async): all outputs 0, all voice counters/pitches 0, FSM IDLE. Deassertion is sampled synchronously by the next clk edge.
- All outputs are registered.
- Per-voice state: busy bit, pitch, remaining beat count.
  - On beat with play=1, every busy voice with remaining>0 decrements.
  - When remaining transitions to 0, busy clears on that same edge; voice_active falls on that edge.
- Allocation happens on the edge where new_note=1 (cycle t); effects are visible in t+1.
  - note=0 (rest) or duration=0: no voice is allocated.
  - Otherwise choose the lowest-index voice with busy=0, using registered busy from cycle t.
  - If all voices are busy, steal the voice with the smallest remaining count (tie: lowest index).
  - Chosen voice: pitch<=note, remaining<=duration, busy<=1; voice_load[k]=1 in t+1 only.
  - A beat in cycle t does not decrement the voice being loaded. Other voices decrement normally.
- Sequencer FSM: states IDLE, GATE, DONE.
  - IDLE, new_note=1, activate=1: activate_done=1 in t+1; stay IDLE.
  - IDLE, new_note=1, activate=0, duration>0: load gate counter with duration; go to GATE.
  - IDLE, new_note=1, activate=0, duration=0: go to DONE (note_done in t+1).
  - GATE: on beat with play=1, decrement the gate counter. When it reaches 0, go to DONE.
  - DONE: note_done=1 for exactly one cycle; return to IDLE. A new_note in DONE is handled as in IDLE.
  - new_note while in GATE (protocol violation): reload the gate counter; handle the voice normally; no note_done for the abandoned note.
- The gate counter is independent of voice counters. A rest still times via the gate.
- play=0: beats are ignored everywhere; new_note is still accepted and allocated.
- flush=1: on the next edge, all busy/remaining/gate counters clear and FSM goes to IDLE. No note_done/activate_done/voice_load is emitted that cycle. flush overrides a simultaneous new_note.
- Widths: counters are DURATION_WIDTH unsigned, never wrap below 0. Allocation selection is purely combinational on registered state.

Decomposition:
- Shared package: state encodings (SCHED_IDLE, SCHED_GATE, SCHED_DONE), REST_NOTE=0, default NOTE_WIDTH/DURATION_WIDTH shared with song_reader.
- One natural sub-module: voice_slot. It holds busy, pitch, and remaining for one voice, with load/beat/flush inputs and a busy/remaining output.
- voice_scheduler instantiates NUM_VOICES voice_slots plus the allocator, gate counter and FSM; state registers use dffr-style flops with async active-low clear.

Test Plan:
- Reset mid-GATE → all outputs 0 immediately, no note_done after release.
  - Stimulus: note=10, dur=4, act=0; 2 beats; then reset=0 asynchronously.
- Normal note:
  - Stimulus: new_note note=20 dur=3 act=0 at t, play=1, beats at t+2, t+5, t+8.
  - Response: voice_load=3'b001 and voice_active[0]=1 at t+1; voice_note[5:0]=20; after the third beat, voice_active[0]=0 and one note_done pulse.
- Chord:
  - Stimulus: three notes (12 dur 4 act=1, 16 dur 4 act=1, 19 dur 4 act=0) on consecutive new_notes.
  - Response: activate_done after the first two; voices 0, 1, 2 active with pitches 12, 16, 19; note_done only after 4 beats.
- Steal:
  - Stimulus: voices hold remaining 5, 2, 7; new chord note 30 dur 6.
  - Response: voice 1 reloaded (voice_load=3'b010, pitch 30).
- Rest / zero-length / pause:
  - note=0 dur=2 act=0 → no voice_load; note_done after 2 beats.
  - dur=0 → note_done in t+1.
  - play=0 with 5 beats → counters unchanged.
- Flush with simultaneous new_note → all voice_active=0 next cycle, no voice_load, FSM IDLE.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler slice.
// Holds the sequencer state encoding, the rest-note code and the default
// note/duration widths that song_reader also uses.
package voice_scheduler_pkg;

  localparam int unsigned DEF_NOTE_WIDTH     = 6;
  localparam int unsigned DEF_DURATION_WIDTH = 6;
  localparam int unsigned REST_NOTE          = 0;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_GATE = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/voice_scheduler_if.sv
// Sequencing handshake between song_reader (master) and voice_scheduler (slave).
//   new_note      : one-cycle note event; note/duration/activate valid with it
//   note          : pitch code (0 = rest)
//   duration      : length in beats
//   activate      : 1 = chord note, 0 = normal note
//   note_done     : pulse when a normal note's duration has expired
//   activate_done : pulse when a chord note has been accepted
interface voice_scheduler_if #(
  parameter int unsigned NOTE_WIDTH     = voice_scheduler_pkg::DEF_NOTE_WIDTH,
  parameter int unsigned DURATION_WIDTH = voice_scheduler_pkg::DEF_DURATION_WIDTH
);
  logic                      new_note;
  logic [NOTE_WIDTH-1:0]     note;
  logic [DURATION_WIDTH-1:0] duration;
  logic                      activate;
  logic                      note_done;
  logic                      activate_done;

  modport master (
    output new_note, note, duration, activate,
    input  note_done, activate_done
  );

  modport slave (
    input  new_note, note, duration, activate,
    output note_done, activate_done
  );
endinterface

// File: rtl/voice_scheduler_voice_slot.sv
// One note_player voice: busy flag, pitch and remaining beat count.
//   clk, rst_n     : clock, asynchronous active-low clear
//   flush          : synchronous clear of busy/remaining (pitch retained)
//   load           : restart with load_note/load_duration (wins over tick)
//   tick           : counted beat (beat gated by play)
//   busy           : voice is sounding
//   pitch          : current pitch code
//   remaining      : beats left
module voice_slot import voice_scheduler_pkg::*; #(
  parameter int unsigned NOTE_WIDTH     = DEF_NOTE_WIDTH,
  parameter int unsigned DURATION_WIDTH = DEF_DURATION_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      load,
  input  logic                      tick,
  input  logic [NOTE_WIDTH-1:0]     load_note,
  input  logic [DURATION_WIDTH-1:0] load_duration,
  output logic                      busy,
  output logic [NOTE_WIDTH-1:0]     pitch,
  output logic [DURATION_WIDTH-1:0] remaining
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      pitch     <= '0;
      remaining <= '0;
    end else if (flush) begin
      busy      <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      busy      <= 1'b1;
      pitch     <= load_note;
      remaining <= load_duration;
    end else if (tick && busy && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
      // busy drops on the same edge the count reaches zero
      if (remaining == DURATION_WIDTH'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates note_player voices for song_reader note events and times the
// sequencer gate that produces note_done / activate_done.
//   clk, reset   : clock, asynchronous active-low reset
//   play         : 1 = beats counted, 0 = all timers frozen
//   flush        : synchronous clear of all voices and the gate
//   beat         : one-cycle beat strobe
//   seq          : song_reader handshake (slave side)
//   voice_load   : per-voice restart pulse
//   voice_active : per-voice sounding flag
//   voice_note   : flattened pitch, voice k at [k*NOTE_WIDTH +: NOTE_WIDTH]
module voice_scheduler import voice_scheduler_pkg::*; #(
  parameter int unsigned NUM_VOICES     = 3,
  parameter int unsigned NOTE_WIDTH     = DEF_NOTE_WIDTH,
  parameter int unsigned DURATION_WIDTH = DEF_DURATION_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             play,
  input  logic                             flush,
  input  logic                             beat,
  voice_scheduler_if.slave                 seq,
  output logic [NUM_VOICES-1:0]            voice_load,
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note
);

  logic                      tick;
  logic                      alloc_en;
  logic [NUM_VOICES-1:0]     busy;
  logic [NUM_VOICES-1:0]     load_sel;
  logic [NUM_VOICES-1:0]     free_sel;
  logic [NUM_VOICES-1:0]     steal_sel;
  logic                      free_found;
  logic [DURATION_WIDTH-1:0] min_rem;
  logic [DURATION_WIDTH-1:0] remaining [NUM_VOICES];

  sched_state_e              state, state_nx;
  logic [DURATION_WIDTH-1:0] gate, gate_nx;
  logic                      act_done_q, act_done_nx;

  assign tick     = beat & play;
  assign alloc_en = seq.new_note & ~flush
                  & (seq.note != NOTE_WIDTH'(REST_NOTE))
                  & (seq.duration != '0);

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
    voice_slot #(
      .NOTE_WIDTH    (NOTE_WIDTH),
      .DURATION_WIDTH(DURATION_WIDTH)
    ) u_slot (
      .clk          (clk),
      .rst_n        (reset),
      .flush        (flush),
      .load         (load_sel[k]),
      .tick         (tick),
      .load_note    (seq.note),
      .load_duration(seq.duration),
      .busy         (busy[k]),
      .pitch        (voice_note[k*NOTE_WIDTH +: NOTE_WIDTH]),
      .remaining    (remaining[k])
    );
  end

  assign voice_active = busy;

  // Lowest free voice first; otherwise steal the smallest remaining count,
  // strict '<' keeps the lowest index on ties.
  always_comb begin
    free_sel   = '0;
    free_found = 1'b0;
    for (int unsigned k = 0; k < NUM_VOICES; k++) begin
      if (!busy[k] && !free_found) begin
        free_sel[k] = 1'b1;
        free_found  = 1'b1;
      end
    end
    steal_sel    = '0;
    steal_sel[0] = 1'b1;
    min_rem      = remaining[0];
    for (int unsigned k = 1; k < NUM_VOICES; k++) begin
      if (remaining[k] < min_rem) begin
        min_rem      = remaining[k];
        steal_sel    = '0;
        steal_sel[k] = 1'b1;
      end
    end
    load_sel = '0;
    if (alloc_en) load_sel = free_found ? free_sel : steal_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) voice_load <= '0;
    else        voice_load <= load_sel;
  end

  // Gate timing runs first, then a new_note overrides it, so a note arriving
  // mid-gate abandons the old note without producing its note_done.
  always_comb begin
    state_nx    = state;
    gate_nx     = gate;
    act_done_nx = 1'b0;
    case (state)
      SCHED_GATE: begin
        if (tick) begin
          if (gate <= DURATION_WIDTH'(1)) begin
            gate_nx  = '0;
            state_nx = SCHED_DONE;
          end else begin
            gate_nx = gate - 1'b1;
          end
        end
      end
      SCHED_DONE: state_nx = SCHED_IDLE;
      default:    state_nx = SCHED_IDLE;
    endcase
    if (seq.new_note) begin
      if (seq.activate) begin
        act_done_nx = 1'b1;
      end else if (seq.duration == '0) begin
        gate_nx  = '0;
        state_nx = SCHED_DONE;
      end else begin
        gate_nx  = seq.duration;
        state_nx = SCHED_GATE;
      end
    end
    if (flush) begin
      state_nx    = SCHED_IDLE;
      gate_nx     = '0;
      act_done_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCHED_IDLE;
      gate       <= '0;
      act_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      gate       <= gate_nx;
      act_done_q <= act_done_nx;
    end
  end

  assign seq.note_done     = (state == SCHED_DONE);
  assign seq.activate_done = act_done_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;
  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic reset;
  logic play;
  logic flush;
  logic beat;
  logic [NV-1:0]    voice_load;
  logic [NV-1:0]    voice_active;
  logic [NV*NW-1:0] voice_note;

  int errors = 0;
  int checks = 0;

  voice_scheduler_if #(.NOTE_WIDTH(NW), .DURATION_WIDTH(DW)) sif ();

  voice_scheduler #(
    .NUM_VOICES    (NV),
    .NOTE_WIDTH    (NW),
    .DURATION_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .flush       (flush),
    .beat        (beat),
    .seq         (sif.slave),
    .voice_load  (voice_load),
    .voice_active(voice_active),
    .voice_note  (voice_note)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_busy [NV];
  int          m_rem  [NV];
  logic [NW-1:0] m_pitch [NV];
  int          m_gate;
  bit          m_gate_run;
  bit          m_tick;
  bit          m_nd;
  int          m_sel;
  bit          exp_nd;
  bit          exp_ad;
  logic [NV-1:0] exp_load = '0;

  task automatic model_clear_all();
    for (int k = 0; k < NV; k++) begin
      m_busy[k] = 1'b0; m_rem[k] = 0; m_pitch[k] = '0;
    end
    m_gate = 0; m_gate_run = 1'b0;
    exp_nd = 1'b0; exp_ad = 1'b0; exp_load = '0;
  endtask

  initial begin
    model_clear_all();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_clear_all();
      end else if (flush) begin
        for (int k = 0; k < NV; k++) begin
          m_busy[k] = 1'b0; m_rem[k] = 0;
        end
        m_gate = 0; m_gate_run = 1'b0;
        exp_nd = 1'b0; exp_ad = 1'b0; exp_load = '0;
      end else begin
        m_tick = beat && play;
        m_sel  = -1;
        if (sif.new_note && sif.note != 0 && sif.duration != 0) begin
          for (int k = 0; k < NV; k++)
            if (!m_busy[k] && m_sel < 0) m_sel = k;
          if (m_sel < 0) begin
            m_sel = 0;
            for (int k = 1; k < NV; k++)
              if (m_rem[k] < m_rem[m_sel]) m_sel = k;
          end
        end
        exp_load = '0;
        for (int k = 0; k < NV; k++) begin
          if (k == m_sel) begin
            m_busy[k] = 1'b1; m_rem[k] = int'(sif.duration); m_pitch[k] = sif.note;
            exp_load[k] = 1'b1;
          end else if (m_tick && m_busy[k]) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) m_busy[k] = 1'b0;
          end
        end
        m_nd = 1'b0;
        if (m_gate_run && m_tick) begin
          m_gate = m_gate - 1;
          if (m_gate == 0) begin m_gate_run = 1'b0; m_nd = 1'b1; end
        end
        if (sif.new_note && !sif.activate) begin
          m_gate     = int'(sif.duration);
          m_gate_run = (sif.duration != 0);
          m_nd       = (sif.duration == 0);
        end
        exp_nd = m_nd;
        exp_ad = sif.new_note && sif.activate;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, half a period after the edge.
  logic [NV-1:0]    exp_active;
  logic [NV*NW-1:0] exp_note;
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NV; k++) begin
        exp_active[k] = m_busy[k];
        exp_note[k*NW +: NW] = m_pitch[k];
      end
      chk("voice_load", voice_load, exp_load);
      chk("voice_active", voice_active, exp_active);
      chk("voice_note", voice_note, exp_note);
      chk("note_done", sif.note_done, exp_nd);
      chk("activate_done", sif.activate_done, exp_ad);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit nn, input int n, input int d, input bit a, input bit b, input bit f);
    @(negedge clk);
    sif.new_note = nn;
    sif.note     = NW'(n);
    sif.duration = DW'(d);
    sif.activate = a;
    beat         = b;
    flush        = f;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      idle();
    end
  endtask

  logic [NV*NW-1:0] vn;

  initial begin
    reset = 1'b0; play = 1'b1; flush = 1'b0; beat = 1'b0;
    sif.new_note = 1'b0; sif.note = '0; sif.duration = '0; sif.activate = 1'b0;
    idle(); idle();
    chk("rst_active", voice_active, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_load", voice_load, 0);
    chk("rst_done", sif.note_done, 0);
    reset = 1'b1;
    idle();

    // normal note: 20 for 3 beats
    drive(1'b1, 20, 3, 1'b0, 1'b0, 1'b0);
    idle();
    chk("norm_load", voice_load, 3'b001);
    chk("norm_active0", voice_active[0], 1);
    vn = voice_note;
    chk("norm_pitch0", vn[5:0], 20);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); idle(); idle();
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); idle(); idle();
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0); idle();
    chk("norm_active_off", voice_active[0], 0);
    chk("norm_done", sif.note_done, 1);
    idle();
    chk("norm_done_pulse", sif.note_done, 0);

    // chord 12,16 (act) + 19 (normal), 4 beats each
    drive(1'b1, 12, 4, 1'b1, 1'b0, 1'b0); idle();
    chk("chord_ad1", sif.activate_done, 1);
    drive(1'b1, 16, 4, 1'b1, 1'b0, 1'b0); idle();
    chk("chord_ad2", sif.activate_done, 1);
    drive(1'b1, 19, 4, 1'b0, 1'b0, 1'b0); idle();
    chk("chord_active", voice_active, 3'b111);
    chk("chord_pitches", voice_note, {6'd19, 6'd16, 6'd12});
    chk("chord_ad3", sif.activate_done, 0);
    beat_idle(3);
    chk("chord_not_done", sif.note_done, 0);
    beat_idle(1);
    chk("chord_done", sif.note_done, 1);
    chk("chord_released", voice_active, 0);

    // steal: remaining 5,2,7 then chord note 30 dur 6
    drive(1'b1, 40, 5, 1'b1, 1'b0, 1'b0); idle();
    drive(1'b1, 41, 2, 1'b1, 1'b0, 1'b0); idle();
    drive(1'b1, 42, 7, 1'b1, 1'b0, 1'b0); idle();
    drive(1'b1, 30, 6, 1'b1, 1'b0, 1'b0); idle();
    chk("steal_load", voice_load, 3'b010);
    vn = voice_note;
    chk("steal_pitch1", vn[11:6], 30);

    // flush with simultaneous new_note
    drive(1'b1, 25, 3, 1'b0, 1'b0, 1'b1); idle();
    chk("flush_active", voice_active, 0);
    chk("flush_load", voice_load, 0);
    chk("flush_done", sif.note_done, 0);

    // zero-length note right after flush (sequencer must be idle)
    drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b0); idle();
    chk("zero_done", sif.note_done, 1);
    chk("zero_load", voice_load, 0);

    // rest times via the gate only
    drive(1'b1, 0, 2, 1'b0, 1'b0, 1'b0); idle();
    chk("rest_load", voice_load, 0);
    beat_idle(1);
    chk("rest_not_done", sif.note_done, 0);
    beat_idle(1);
    chk("rest_done", sif.note_done, 1);

    // pause: 5 beats ignored
    play = 1'b0;
    drive(1'b1, 9, 3, 1'b0, 1'b0, 1'b0); idle();
    beat_idle(5);
    chk("pause_active", voice_active[0], 1);
    chk("pause_not_done", sif.note_done, 0);
    play = 1'b1;
    beat_idle(3);
    chk("pause_done", sif.note_done, 1);
    chk("pause_released", voice_active[0], 0);

    // new normal note during GATE reloads the gate
    drive(1'b1, 5, 2, 1'b0, 1'b0, 1'b0); idle();
    drive(1'b1, 6, 3, 1'b0, 1'b0, 1'b0); idle();
    beat_idle(2);
    chk("reload_not_done", sif.note_done, 0);
    beat_idle(1);
    chk("reload_done", sif.note_done, 1);

    // asynchronous reset in the middle of a gate
    drive(1'b1, 10, 4, 1'b0, 1'b0, 1'b0); idle();
    beat_idle(2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_active", voice_active, 0);
    chk("mid_rst_note", voice_note, 0);
    chk("mid_rst_done", sif.note_done, 0);
    idle(); idle();
    reset = 1'b1;
    beat_idle(4);
    chk("post_rst_done", sif.note_done, 0);

    // randomized traffic, protocol-respecting (no new_note while gating)
    for (int i = 0; i < 3000; i++) begin
      drive(!m_gate_run && ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
            ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 80) == 0));
      play = ($urandom_range(0, 9) != 0);
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
